// File: rtl/hilo_muldiv_sequencer_pkg.sv
// rtl/hilo_muldiv_sequencer_pkg.sv - shared funct codes, FSM states and decode helpers
package hilo_muldiv_sequencer_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_t;

  function automatic logic is_mul_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

  function automatic logic is_div_funct(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return is_mul_funct(f) || is_div_funct(f) ||
           (f == FUNCT_MFHI) || (f == FUNCT_MTHI) || (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
  endfunction

  // Signed variants (mult, div) have funct bit 0 clear.
  function automatic logic is_signed_funct(input logic [5:0] f);
    return ~f[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_datapath.sv
// rtl/hilo_muldiv_sequencer_datapath.sv - shift-add multiply / restoring divide on magnitudes, sign fix-up
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             div_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_reg;
  logic               div_mode;
  logic               neg_lo;
  logic               neg_hi;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;

  assign a_mag    = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag    = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign div_zero = is_div && (op_b == '0);

  // Multiply: multiplier sits in acc low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: partial remainder in acc high half, quotient bits shift into the low half.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, b_reg};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_neg = -acc;
  assign quo_neg  = -acc[WIDTH-1:0];
  assign rem_neg  = -acc[2*WIDTH-1:WIDTH];

  always_comb begin
    if (div_mode) begin
      res_hi = neg_hi ? rem_neg : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_lo ? quo_neg : acc[WIDTH-1:0];
    end else begin
      res_hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_lo ? prod_neg[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Divide by zero preloads the final {HI,LO} so FIX just passes it through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      b_reg    <= '0;
      div_mode <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      if (div_zero) begin
        acc    <= {op_a, {WIDTH{1'b1}}};
        b_reg  <= '0;
        neg_lo <= 1'b0;
        neg_hi <= 1'b0;
      end else if (is_div) begin
        acc    <= {{WIDTH{1'b0}}, a_mag};
        b_reg  <= b_mag;
        neg_lo <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        neg_hi <= is_signed && op_a[WIDTH-1];
      end else begin
        acc    <= {{WIDTH{1'b0}}, b_mag};
        b_reg  <= a_mag;
        neg_lo <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        neg_hi <= 1'b0;
      end
    end else if (step) begin
      acc <= div_mode ? div_next : mul_next;
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - HI/LO owner: mul/div sequencing, pipeline stall, mf/mt access
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] mf_data,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  hilo_state_t      state, state_next;
  logic [CW-1:0]    cnt;
  logic             dz_pend;
  logic             take, accept_mul, accept_div, load, step, last_iter, dp_dz;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign take       = (state == ST_IDLE) && req && !flush;
  assign accept_mul = take && is_mul_funct(funct);
  assign accept_div = take && is_div_funct(funct);
  assign load       = accept_mul || accept_div;
  assign step       = (state == ST_MUL) || (state == ST_DIV);
  assign last_iter  = (cnt == CW'(WIDTH - 1));

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .is_div    (is_div_funct(funct)),
    .is_signed (is_signed_funct(funct)),
    .step      (step),
    .op_a      (op_a),
    .op_b      (op_b),
    .div_zero  (dp_dz),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept_mul)      state_next = ST_MUL;
        else if (accept_div) state_next = dp_dz ? ST_FIX : ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (flush)          state_next = ST_IDLE;
        else if (last_iter) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    stall   = req && is_hilo_funct(funct) && busy;
    mf_data = '0;
    if (funct == FUNCT_MFHI)      mf_data = hi_out;
    else if (funct == FUNCT_MFLO) mf_data = lo_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dz_pend <= 1'b0;
    end else begin
      cnt <= step ? cnt + CW'(1) : '0;
      if (load) dz_pend <= dp_dz;
    end
  end

  // A flush in FIX suppresses the write-back, leaving HI/LO and the sticky flag intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else if (state == ST_FIX) begin
      if (!flush) begin
        hi_out   <= res_hi;
        lo_out   <= res_lo;
        div_zero <= dz_pend;
      end
    end else begin
      if (load)                            div_zero <= 1'b0;
      if (take && funct == FUNCT_MTHI)     hi_out   <= op_a;
      if (take && funct == FUNCT_MTLO)     lo_out   <= op_a;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - scoreboard bench for the HI/LO mul/div sequencer
module tb_hilo_muldiv_sequencer;
  import hilo_muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [5:0]   funct;
  logic [W-1:0] op_a, op_b;
  logic         flush;
  logic         busy, stall, div_zero;
  logic [W-1:0] hi_out, lo_out, mf_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [64:0]  sb[$];
  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_dz;

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .funct(funct), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall), .hi_out(hi_out), .lo_out(lo_out),
    .mf_data(mf_data), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [64:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint      sa, sb_, q, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (f)
      FUNCT_MULT:  begin p = 64'(sa * sb_); return {1'b0, p}; end
      FUNCT_MULTU: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      FUNCT_DIV: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb_; r = sa % sb_;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Drives the request, waits out any stall, leaves at the negedge of cycle T+1 with req low.
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int g = 0;
    @(negedge clk);
    req = 1'b1; funct = f; op_a = a; op_b = b;
    while (stall && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("accept_timeout", 64'(g), 64'd0);
    if (push) sb.push_back(model(f, a, b));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [64:0] e;
    if (sb.size() == 0) begin chk({tag, "_sb_empty"}, 64'd0, 64'd1); return; end
    e = sb.pop_front();
    chk({tag, "_hi"}, 64'(hi_out), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo_out), 64'(e[31:0]));
    chk({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
    exp_hi = e[63:32]; exp_lo = e[31:0]; exp_dz = e[64];
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    bit dz;
    dz = is_div_funct(f) && (b == 0);
    start_op(f, a, b, 1'b1);
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk({tag, "_busy_cycles"}, 64'(n), dz ? 64'd1 : 64'(W + 1));
    check_result(tag);
  endtask

  // Issue an op, then hold an mf read in the following cycle until it is released.
  task automatic op_then_mf(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [5:0] mf);
    int n = 0;
    logic [64:0] e;
    start_op(f, a, b, 1'b1);
    e = sb[sb.size()-1];
    req = 1'b1; funct = mf;
    #1;
    while (stall && n < 100) begin n++; @(negedge clk); end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, "_mf_data"}, 64'(mf_data), (mf == FUNCT_MFHI) ? 64'(e[63:32]) : 64'(e[31:0]));
    req = 1'b0;
    check_result(tag);
  endtask

  initial begin
    logic [5:0] fr;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; req = 1'b0; funct = '0; op_a = '0; op_b = '0; flush = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_const", 64'(exp_hi), 64'hFFFF_FFFE);
    run_op("mult_neg", FUNCT_MULT, -32'sd3, 32'd7);
    chk("mult_neg_lo_const", 64'(exp_lo), 64'hFFFF_FFEB);
    run_op("div_neg", FUNCT_DIV, -32'sd7, 32'd2);
    run_op("divu_zero", FUNCT_DIVU, 32'd100, 32'd0);
    run_op("multu_small", FUNCT_MULTU, 32'd2, 32'd3);
    run_op("div_zero_signed", FUNCT_DIV, -32'sd5, 32'd0);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    op_then_mf("div_mfhi", FUNCT_DIV, 32'd1000, -32'sd7, FUNCT_MFHI);

    @(negedge clk);
    req = 1'b1; funct = FUNCT_MTHI; op_a = 32'h1234;
    #1 chk("mthi_stall", 64'(stall), 64'd0);
    @(negedge clk);
    req = 1'b0;
    chk("mthi_hi", 64'(hi_out), 64'h1234);
    chk("mthi_lo_kept", 64'(lo_out), 64'(exp_lo));
    exp_hi = 32'h1234;
    req = 1'b1; funct = FUNCT_MTLO; op_a = 32'hCAFE_0001;
    @(negedge clk);
    req = 1'b0;
    chk("mtlo_lo", 64'(lo_out), 64'hCAFE_0001);
    chk("mtlo_hi_kept", 64'(hi_out), 64'(exp_hi));
    exp_lo = 32'hCAFE_0001;

    // A non-HI/LO instruction must not stall while an op is in flight.
    start_op(FUNCT_MULTU, 32'd11, 32'd13, 1'b1);
    req = 1'b1; funct = 6'h20;
    #1 chk("nonhilo_stall", 64'(stall), 64'd0);
    chk("nonhilo_busy", 64'(busy), 64'd1);
    req = 1'b0;
    begin
      int n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
    end
    check_result("multu_bg");

    // Flush during iteration 10: nothing written.
    start_op(FUNCT_MULT, 32'd5, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi_out), 64'(exp_hi));
    chk("flush_lo", 64'(lo_out), 64'(exp_lo));

    // Flush in IDLE with a request: ignored.
    @(negedge clk);
    req = 1'b1; funct = FUNCT_MULTU; op_a = 32'd4; op_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide.
    start_op(FUNCT_DIVU, 32'd999, 32'd7, 1'b0);
    req = 1'b1; funct = FUNCT_MFLO;
    repeat (5) @(negedge clk);
    #7 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_hi", 64'(hi_out), 64'd0);
    chk("arst_lo", 64'(lo_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;

    op_then_mf("mult_mflo", FUNCT_MULT, 32'h0001_2345, -32'sd321, FUNCT_MFLO);

    for (int i = 0; i < 6; i++) begin
      fr = 6'h18 + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d", i), fr, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
